passcode_lock: RTL and testbench
================================

PASSCODE_LOCK -- requirements
Module: passcode_lock

Interface
REQ-001 SHALL have parameter DIGITS, default 3, passcode length in BCD digits (1..8).
REQ-002 SHALL have parameter PASSWORD, default 12'h246, DIGITS*4-bit BCD passcode, most significant digit first.
REQ-003 SHALL have parameter MAX_TRIES, default 6, consecutive failures that force LOCKOUT.
REQ-004 SHALL have parameter CLICK_CYC, default 10_000_000, key-click tone duration in clk cycles.
REQ-005 SHALL have parameter RESULT_CYC, default 50_000_000, pass/fail tone duration in clk cycles.
REQ-006 SHALL have parameters CLICK_HALF, PASS_HALF and FAIL_HALF, defaults 50_000, 10_000 and 25_000, buzzer half-periods in clk cycles.
REQ-007 SHALL have parameter LOCKOUT_CYC, default 500_000_000, auto-unlock delay; used only under REQ-030.
REQ-008 clk  input  1  system clock, all logic on posedge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 onehot  input  16  keypad code: 0x0008/0080/0040/0020/0800/0400/0200/8000/4000/2000 = digits 0..9; 0x0001 enter; 0x1000 clear entry; 0x0100 clear all.
REQ-011 binary  output  4*DIGITS  display nibbles, newest digit in [3:0]; 4'hF = blank.
REQ-012 times  output  $clog2(DIGITS+1)  digits entered.
REQ-013 tries  output  $clog2(MAX_TRIES+1)  consecutive failed attempts.
REQ-014 buzzer  output  1  square-wave buzzer drive.
REQ-015 unlocked / locked_out  output  1 each  high in PASS / LOCKOUT state.

Function
REQ-016 Key event SHALL be flagged when onehot equals a listed code and differs from its previous-cycle value; unlisted or multi-hot codes SHALL be ignored, so a repeated digit requires a release.
REQ-017 All outputs SHALL be registered; a key event sampled at edge N SHALL be visible on outputs after edge N+1.
REQ-018 States ENTRY, PASS, LOCKOUT; reset state ENTRY.
REQ-019 ENTRY, digit with times<DIGITS: binary shifted left one nibble, digit into [3:0], times+1, click tone started; digit with times==DIGITS: ignored, no tone.
REQ-020 ENTRY, enter with times<DIGITS: ignored.
REQ-021 ENTRY, enter with times==DIGITS and binary==PASSWORD: go PASS, binary all 4'hE, times 0, tries 0, pass tone.
REQ-022 ENTRY, enter with mismatch: binary all 4'hF, times 0, tries+1, fail tone; if tries+1==MAX_TRIES go LOCKOUT, binary all 4'h0.
REQ-023 Clear entry (0x1000) in ENTRY or PASS: binary all 4'hF, times 0, go ENTRY; tries unchanged; ignored in LOCKOUT.
REQ-024 Clear all (0x0100) in any state: binary all 4'hF, times 0, tries 0, go ENTRY, tone stopped.
REQ-025 PASS and LOCKOUT SHALL ignore digits and enter.
REQ-026 Tone: start loads duration counter and sets buzzer=1; buzzer toggles every half-period cycles; at expiry buzzer=0; idle buzzer=0.
REQ-027 Tone priority pass = fail > click; a click SHALL NOT start while a pass/fail tone runs; a new tone of equal or higher priority restarts both counters.

Reset
REQ-028 rst SHALL force ENTRY, binary all 4'hF, times 0, tries 0, buzzer 0, unlocked 0, locked_out 0, and clear all counters and the key-edge register; rst overrides a simultaneous key event.
REQ-029 Mid-tone or mid-lockout reset SHALL abort immediately, with no residual buzzer pulse.

Configuration
REQ-030 With PASSCODE_LOCK_LOCKOUT_TIMER_EN defined, LOCKOUT SHALL exit to ENTRY after LOCKOUT_CYC cycles, with tries 0 and binary all 4'hF; without it, LOCKOUT exits only via clear all or rst, and the timer logic is absent.

Verification
REQ-031 Keys 2,4,6, enter (each released) -> binary 0x246 then 0xEEE, unlocked=1, tries 0, pass tone PASS_HALF toggles for RESULT_CYC.
REQ-032 Keys 1,1,1 with releases, then 0x0080 held 5 cycles -> times 3 (held key counted once), binary 0x111.
REQ-033 Wrong code 1,2,3, enter, 6 times -> tries 1..5 with 0xFFF, then locked_out=1, binary 0x000; further digits ignored.
REQ-034 In LOCKOUT press 0x0100 -> ENTRY, tries 0, binary 0xFFF next cycle; with macro defined and no key -> same after LOCKOUT_CYC cycles.
REQ-035 Digit event on the same edge as rst=1 -> reset values, times 0; digit during pass tone -> digit ignored (PASS), tone uninterrupted.

Source files
------------

// File: rtl/passcode_lock.sv
// passcode_lock -- keypad passcode lock with buzzer feedback.
//
// A 16-bit one-hot keypad code is edge-detected and registered, then drives
// a three-state controller (ENTRY / PASS / LOCKOUT) and a tone generator.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous, active-high reset
//   onehot      keypad code (digits 0..9, enter, clear entry, clear all)
//   binary      display nibbles, newest digit in [3:0], 4'hF = blank
//   times       number of digits entered so far
//   tries       consecutive failed attempts
//   buzzer      square-wave buzzer drive
//   unlocked    high in PASS
//   locked_out  high in LOCKOUT
//
// Optional feature: define PASSCODE_LOCK_LOCKOUT_TIMER_EN to make LOCKOUT
// exit to ENTRY by itself after LOCKOUT_CYC cycles.
module passcode_lock #(
   parameter int                  DIGITS      = 3,
   parameter logic [DIGITS*4-1:0] PASSWORD    = 12'h246,
   parameter int                  MAX_TRIES   = 6,
   parameter int                  CLICK_CYC   = 10_000_000,
   parameter int                  RESULT_CYC  = 50_000_000,
   parameter int                  CLICK_HALF  = 50_000,
   parameter int                  PASS_HALF   = 10_000,
   parameter int                  FAIL_HALF   = 25_000,
   parameter int                  LOCKOUT_CYC = 500_000_000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [15:0]                    onehot,
   output logic [4*DIGITS-1:0]            binary,
   output logic [$clog2(DIGITS+1)-1:0]    times,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries,
   output logic                           buzzer,
   output logic                           unlocked,
   output logic                           locked_out
);

   localparam int TW  = $clog2(DIGITS+1);
   localparam int TRW = $clog2(MAX_TRIES+1);
   localparam logic [TW-1:0]  DIG_L = TW'(DIGITS);
   localparam logic [TRW-1:0] MAX_L = TRW'(MAX_TRIES);

   localparam logic [1:0] ST_ENTRY = 2'd0;
   localparam logic [1:0] ST_PASS  = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   // Non-digit key identifiers carried in the low nibble of the decoded key.
   localparam logic [3:0] K_ENTER   = 4'd1;
   localparam logic [3:0] K_CLR_ENT = 4'd2;
   localparam logic [3:0] K_CLR_ALL = 4'd3;

   // Decoded key: [5] listed code, [4] digit, [3:0] digit value or key id.
   function automatic logic [5:0] decode(input logic [15:0] c);
      case (c)
         16'h0008: decode = {2'b11, 4'd0};
         16'h0080: decode = {2'b11, 4'd1};
         16'h0040: decode = {2'b11, 4'd2};
         16'h0020: decode = {2'b11, 4'd3};
         16'h0800: decode = {2'b11, 4'd4};
         16'h0400: decode = {2'b11, 4'd5};
         16'h0200: decode = {2'b11, 4'd6};
         16'h8000: decode = {2'b11, 4'd7};
         16'h4000: decode = {2'b11, 4'd8};
         16'h2000: decode = {2'b11, 4'd9};
         16'h0001: decode = {2'b10, K_ENTER};
         16'h1000: decode = {2'b10, K_CLR_ENT};
         16'h0100: decode = {2'b10, K_CLR_ALL};
         default:  decode = 6'd0;
      endcase
   endfunction

   // Key stage: an event is a listed code that differs from last cycle, so a
   // held key counts once and a repeated digit needs a release in between.
   logic [15:0] prev_q, prev_d;
   logic        kev_q, kev_d;
   logic [5:0]  kdec_q, kdec_d;

   always_comb begin
      prev_d = onehot;
      kdec_d = decode(onehot);
      kev_d  = kdec_d[5] && (onehot != prev_q);
   end

   // Controller
   logic [1:0]           state_q, state_d;
   logic [4*DIGITS-1:0]  binary_q, binary_d, shifted;
   logic [TW-1:0]        times_q, times_d;
   logic [TRW-1:0]       tries_q, tries_d;
   logic                 unl_q, unl_d, lo_q, lo_d;
   logic                 click_start, result_start, result_fail, tone_stop;
   logic                 is_digit;
   logic [3:0]           kval;
`ifdef PASSCODE_LOCK_LOCKOUT_TIMER_EN
   logic [31:0]          lock_cnt_q, lock_cnt_d;
`else
   logic                 unused_lockout_cyc;
   assign unused_lockout_cyc = ^LOCKOUT_CYC;
`endif

   always_comb begin
      state_d      = state_q;
      binary_d     = binary_q;
      times_d      = times_q;
      tries_d      = tries_q;
      click_start  = 1'b0;
      result_start = 1'b0;
      result_fail  = 1'b0;
      tone_stop    = 1'b0;
      is_digit     = kdec_q[4];
      kval         = kdec_q[3:0];
      shifted      = binary_q << 4;
      shifted[3:0] = kval;
`ifdef PASSCODE_LOCK_LOCKOUT_TIMER_EN
      // Evaluated before key handling so that clear all still wins.
      lock_cnt_d = 32'd0;
      if (state_q == ST_LOCK) begin
         if (lock_cnt_q == 32'(LOCKOUT_CYC - 1)) begin
            state_d  = ST_ENTRY;
            tries_d  = '0;
            times_d  = '0;
            binary_d = {DIGITS{4'hF}};
         end else begin
            lock_cnt_d = lock_cnt_q + 32'd1;
         end
      end
`endif
      if (kev_q) begin
         if (!is_digit && kval == K_CLR_ALL) begin
            state_d   = ST_ENTRY;
            binary_d  = {DIGITS{4'hF}};
            times_d   = '0;
            tries_d   = '0;
            tone_stop = 1'b1;
         end else if (!is_digit && kval == K_CLR_ENT) begin
            if (state_q != ST_LOCK) begin
               state_d  = ST_ENTRY;
               binary_d = {DIGITS{4'hF}};
               times_d  = '0;
            end
         end else if (state_q == ST_ENTRY) begin
            if (is_digit) begin
               if (times_q != DIG_L) begin
                  binary_d    = shifted;
                  times_d     = times_q + TW'(1);
                  click_start = 1'b1;
               end
            end else if (kval == K_ENTER && times_q == DIG_L) begin
               times_d      = '0;
               result_start = 1'b1;
               if (binary_q == PASSWORD) begin
                  state_d  = ST_PASS;
                  binary_d = {DIGITS{4'hE}};
                  tries_d  = '0;
               end else begin
                  result_fail = 1'b1;
                  binary_d    = {DIGITS{4'hF}};
                  tries_d     = tries_q + TRW'(1);
                  if (tries_d == MAX_L) begin
                     state_d  = ST_LOCK;
                     binary_d = {DIGITS{4'h0}};
                  end
               end
            end
         end
      end
      unl_d = (state_d == ST_PASS);
      lo_d  = (state_d == ST_LOCK);
   end

   // Tone generator: dur counts the tone length, half counts the current
   // half-period; a result tone blocks clicks until it expires.
   logic        tone_on_q, tone_on_d, tone_res_q, tone_res_d, buzz_q, buzz_d;
   logic [31:0] dur_q, dur_d, half_q, half_d, hp_q, hp_d;

   always_comb begin
      tone_on_d  = tone_on_q;
      tone_res_d = tone_res_q;
      buzz_d     = buzz_q;
      dur_d      = dur_q;
      half_d     = half_q;
      hp_d       = hp_q;
      if (tone_on_q) begin
         if (dur_q <= 32'd1) begin
            tone_on_d  = 1'b0;
            tone_res_d = 1'b0;
            buzz_d     = 1'b0;
         end else begin
            dur_d = dur_q - 32'd1;
            if (half_q <= 32'd1) begin
               buzz_d = ~buzz_q;
               half_d = hp_q;
            end else begin
               half_d = half_q - 32'd1;
            end
         end
      end
      if (tone_stop) begin
         tone_on_d  = 1'b0;
         tone_res_d = 1'b0;
         buzz_d     = 1'b0;
      end else if (result_start) begin
         tone_on_d  = 1'b1;
         tone_res_d = 1'b1;
         buzz_d     = 1'b1;
         dur_d      = 32'(RESULT_CYC);
         hp_d       = result_fail ? 32'(FAIL_HALF) : 32'(PASS_HALF);
         half_d     = hp_d;
      end else if (click_start && !(tone_on_q && tone_res_q)) begin
         tone_on_d  = 1'b1;
         tone_res_d = 1'b0;
         buzz_d     = 1'b1;
         dur_d      = 32'(CLICK_CYC);
         hp_d       = 32'(CLICK_HALF);
         half_d     = hp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         kev_q      <= 1'b0;
         kdec_q     <= '0;
         state_q    <= ST_ENTRY;
         binary_q   <= {DIGITS{4'hF}};
         times_q    <= '0;
         tries_q    <= '0;
         unl_q      <= 1'b0;
         lo_q       <= 1'b0;
         tone_on_q  <= 1'b0;
         tone_res_q <= 1'b0;
         buzz_q     <= 1'b0;
         dur_q      <= '0;
         half_q     <= '0;
         hp_q       <= '0;
`ifdef PASSCODE_LOCK_LOCKOUT_TIMER_EN
         lock_cnt_q <= '0;
`endif
      end else begin
         prev_q     <= prev_d;
         kev_q      <= kev_d;
         kdec_q     <= kdec_d;
         state_q    <= state_d;
         binary_q   <= binary_d;
         times_q    <= times_d;
         tries_q    <= tries_d;
         unl_q      <= unl_d;
         lo_q       <= lo_d;
         tone_on_q  <= tone_on_d;
         tone_res_q <= tone_res_d;
         buzz_q     <= buzz_d;
         dur_q      <= dur_d;
         half_q     <= half_d;
         hp_q       <= hp_d;
`ifdef PASSCODE_LOCK_LOCKOUT_TIMER_EN
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign binary     = binary_q;
   assign times      = times_q;
   assign tries      = tries_q;
   assign buzzer     = buzz_q;
   assign unlocked   = unl_q;
   assign locked_out = lo_q;

endmodule

// File: tb/tb_passcode_lock.sv
// tb_passcode_lock -- directed bench for passcode_lock with short tone and
// lockout timings. Inputs change 1 time unit after posedge; outputs are
// sampled at the same point, after the edge has settled.
module tb_passcode_lock;

   localparam logic [15:0] K0 = 16'h0008, K1 = 16'h0080, K2 = 16'h0040;
   localparam logic [15:0] K3 = 16'h0020, K4 = 16'h0800, K5 = 16'h0400;
   localparam logic [15:0] K6 = 16'h0200, K7 = 16'h8000;
   localparam logic [15:0] K_ENT = 16'h0001, K_CE = 16'h1000, K_CA = 16'h0100;
   localparam int LOCK_CYC = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] onehot;
   logic [11:0] binary;
   logic [1:0]  times;
   logic [2:0]  tries;
   logic        buzzer, unlocked, locked_out;

   int total = 0;
   int bad   = 0;
   int hi;

   passcode_lock #(
      .DIGITS(3), .PASSWORD(12'h246), .MAX_TRIES(6),
      .CLICK_CYC(8), .RESULT_CYC(20),
      .CLICK_HALF(2), .PASS_HALF(3), .FAIL_HALF(4),
      .LOCKOUT_CYC(LOCK_CYC)
   ) dut (
      .clk(clk), .rst(rst), .onehot(onehot),
      .binary(binary), .times(times), .tries(tries),
      .buzzer(buzzer), .unlocked(unlocked), .locked_out(locked_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Press and release; returns right after the controller has acted.
   task automatic press_nowait(input logic [15:0] code);
      onehot = code;
      tick();
      onehot = 16'h0;
      tick();
   endtask

   task automatic press(input logic [15:0] code);
      press_nowait(code);
      tick();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      rst    = 1'b1;
      onehot = 16'h0;
      tick();
      tick();
      chk("rst_binary", binary, 12'hFFF);
      chk("rst_times", times, 0);
      chk("rst_tries", tries, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_unlocked", unlocked, 0);
      chk("rst_locked", locked_out, 0);
      rst = 1'b0;
      tick();

      // Correct code; click tone on first digit.
      press_nowait(K2);
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         if (buzzer) hi++;
         tick();
      end
      chk("click_high_cycles", hi, 4);
      chk("first_digit", binary, 12'hFF2);
      press(K4);
      press(K6);
      chk("code_binary", binary, 12'h246);
      chk("code_times", times, 3);
      press_nowait(K_ENT);
      chk("pass_unlocked", unlocked, 1);
      chk("pass_binary", binary, 12'hEEE);
      chk("pass_times", times, 0);
      chk("pass_tries", tries, 0);
      hi = 0;
      for (int k = 0; k < 30; k++) begin
         if (buzzer) hi++;
         if (k == 5) onehot = K3;
         if (k == 7) onehot = 16'h0;
         tick();
      end
      chk("pass_high_cycles", hi, 11);
      chk("pass_tone_end", buzzer, 0);
      chk("pass_digit_ignored", binary, 12'hEEE);
      chk("pass_still_unlocked", unlocked, 1);
      press(K_CE);
      chk("ce_from_pass_unl", unlocked, 0);
      chk("ce_from_pass_bin", binary, 12'hFFF);

      // Repeated digit needs release; held key counts once.
      press(K1);
      press(K1);
      press(K1);
      chk("111_times", times, 3);
      chk("111_binary", binary, 12'h111);
      repeat (12) tick();
      onehot = K1;
      repeat (5) tick();
      onehot = 16'h0;
      tick();
      tick();
      chk("held_full_times", times, 3);
      chk("held_full_binary", binary, 12'h111);
      chk("full_digit_no_tone", buzzer, 0);
      press(K_CE);
      onehot = K1;
      repeat (5) tick();
      onehot = 16'h0;
      tick();
      tick();
      chk("held_once_times", times, 1);
      chk("held_once_binary", binary, 12'hFF1);
      press(K_ENT);
      chk("short_enter_times", times, 1);
      chk("short_enter_unl", unlocked, 0);
      press(K_CE);

      // Six wrong attempts lead to lockout.
      for (int a = 1; a <= 6; a++) begin
         press(K1);
         press(K2);
         press(K3);
         if (a == 1) begin
            press_nowait(K_ENT);
            hi = 0;
            for (int k = 0; k < 24; k++) begin
               if (buzzer) hi++;
               tick();
            end
            chk("fail_high_cycles", hi, 12);
         end else begin
            press(K_ENT);
         end
         chk("fail_tries", tries, a);
         chk("fail_times", times, 0);
         chk("fail_binary", binary, (a == 6) ? 12'h000 : 12'hFFF);
         chk("fail_locked", locked_out, (a == 6) ? 1 : 0);
      end
      press(K5);
      chk("lock_digit_bin", binary, 12'h000);
      chk("lock_digit_times", times, 0);
      press(K_CE);
      chk("lock_ce_ignored", locked_out, 1);
`ifdef PASSCODE_LOCK_LOCKOUT_TIMER_EN
      repeat (LOCK_CYC + 2) tick();
      chk("timer_exit_locked", locked_out, 0);
      chk("timer_exit_tries", tries, 0);
      chk("timer_exit_binary", binary, 12'hFFF);
`else
      repeat (LOCK_CYC + 10) tick();
      chk("no_timer_still_locked", locked_out, 1);
      press_nowait(K_CA);
      chk("ca_lock_locked", locked_out, 0);
      chk("ca_lock_tries", tries, 0);
      chk("ca_lock_binary", binary, 12'hFFF);
`endif

      // Key event coincident with reset.
      press(K_CA);
      press(K1);
      chk("pre_rst_times", times, 1);
      onehot = K3;
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      onehot = 16'h0;
      tick();
      tick();
      chk("rst_key_times", times, 0);
      chk("rst_key_binary", binary, 12'hFFF);

      // Reset in the middle of a pass tone.
      press(K2);
      press(K4);
      press(K6);
      press_nowait(K_ENT);
      tick();
      tick();
      chk("midtone_buzz_on", buzzer, 1);
      rst = 1'b1;
      tick();
      chk("midtone_rst_buzz", buzzer, 0);
      chk("midtone_rst_unl", unlocked, 0);
      rst = 1'b0;
      hi = 0;
      for (int k = 0; k < 25; k++) begin
         if (buzzer) hi++;
         tick();
      end
      chk("midtone_residual", hi, 0);

      // Clear all stops a running click.
      press_nowait(K7);
      chk("click_on", buzzer, 1);
      press_nowait(K_CA);
      chk("ca_stop_buzz", buzzer, 0);
      tick();
      tick();
      chk("ca_stop_buzz_later", buzzer, 0);
      chk("ca_binary", binary, 12'hFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
